// File: rtl/clock_pkg.sv
// clock_pkg
//   Definitions shared by the time-keeping blocks: the set-time mode
//   encoding and the default prescale (system clock cycles per second),
//   which the display block also uses.
package clock_pkg;

  // Set-time FSM encoding; 2'd3 is unused and treated as illegal.
  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2
  } mode_t;

  // System clock cycles per one-second tick.
  localparam int unsigned PRESCALE_DEFAULT = 32'd50_000_000;

  // Successor of a mode on a mode-button event: RUN -> SET_H -> SET_M -> RUN.
  // Any illegal encoding goes back to RUN.
  function automatic mode_t next_mode(input mode_t cur);
    mode_t nxt;
    case (cur)
      MODE_RUN:   nxt = MODE_SET_H;
      MODE_SET_H: nxt = MODE_SET_M;
      MODE_SET_M: nxt = MODE_RUN;
      default:    nxt = MODE_RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/clock_tick_ctrl_tick_gen.sv
// tick_gen
//   Free-running prescale counter, 0..PRESCALE-1, wrapping to 0.
//   Ports:
//     clk    in   system clock, rising edge
//     reset  in   asynchronous active-low reset (count -> 0)
//     clr    in   synchronous reload of the count to 0 (wins over counting)
//     tc     out  terminal count, high while count == PRESCALE-1 (combinational)
//     count  out  current count value
module tick_gen
  import clock_pkg::*;
#(
  parameter  int unsigned PRESCALE = PRESCALE_DEFAULT,
  localparam int unsigned CW       = $clog2(PRESCALE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  output logic          tc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_r;

  assign tc    = (count_r == CW'(PRESCALE - 1));
  assign count = count_r;

  // Prescale counter with synchronous reload and wrap at terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (tc) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

endmodule

// File: rtl/clock_tick_ctrl.sv
// clock_tick_ctrl
//   Sequences the hour/minute/second counters from one clock domain: derives
//   the 1 Hz tick, issues single-cycle increment enables with carry chaining,
//   and runs the button-driven set-time FSM (RUN -> SET_H -> SET_M -> RUN).
//   Optional feature macro: CLOCK_TICK_CTRL_BLINK_EN (blink strobe for the
//   field being set; when undefined, blink is tied low).
//   Ports:
//     clk       in   system clock, rising edge
//     reset     in   asynchronous active-low reset
//     mode_btn  in   debounced/synchronised mode button (level)
//     adj_btn   in   debounced/synchronised adjust button (level)
//     sec_max   in   seconds counter at 59
//     min_max   in   minutes counter at 59
//     tick_1hz  out  one-cycle pulse every PRESCALE cycles
//     sec_inc   out  seconds increment enable
//     min_inc   out  minutes increment enable
//     hour_inc  out  hours increment enable
//     sec_clr   out  seconds synchronous clear
//     mode      out  0=RUN, 1=SET_H, 2=SET_M
//     blink     out  display blank strobe (SET modes only)
module clock_tick_ctrl
  import clock_pkg::*;
#(
  parameter  int unsigned PRESCALE = PRESCALE_DEFAULT,
  localparam int unsigned CW       = $clog2(PRESCALE)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       adj_btn,
  input  logic       sec_max,
  input  logic       min_max,
  output logic       tick_1hz,
  output logic       sec_inc,
  output logic       min_inc,
  output logic       hour_inc,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  mode_t         mode_r;
  logic          mode_q_r;
  logic          adj_q_r;
  logic          tick_1hz_r;
  logic          sec_inc_r;
  logic          min_inc_r;
  logic          hour_inc_r;
  logic          sec_clr_r;
  logic          tc_s;
  logic [CW-1:0] count_s;
  logic          mode_rise_s;
  logic          adj_rise_s;
  logic          exit_set_s;

  assign mode_rise_s = mode_btn & ~mode_q_r;
  assign adj_rise_s  = adj_btn & ~adj_q_r;
  // Leaving SET_M restarts the second so the next tick is a full second away.
  assign exit_set_s  = (mode_r == MODE_SET_M) & mode_rise_s;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (exit_set_s),
    .tc    (tc_s),
    .count (count_s)
  );

  // Button history, set-time FSM and all registered strobe outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_r     <= MODE_RUN;
      mode_q_r   <= 1'b0;
      adj_q_r    <= 1'b0;
      tick_1hz_r <= 1'b0;
      sec_inc_r  <= 1'b0;
      min_inc_r  <= 1'b0;
      hour_inc_r <= 1'b0;
      sec_clr_r  <= 1'b0;
    end else begin
      mode_q_r   <= mode_btn;
      adj_q_r    <= adj_btn;
      tick_1hz_r <= tc_s;
      sec_clr_r  <= exit_set_s;
      case (mode_r)
        MODE_RUN: begin
          sec_inc_r  <= tc_s;
          min_inc_r  <= tc_s & sec_max;
          hour_inc_r <= tc_s & sec_max & min_max;
          mode_r     <= mode_rise_s ? next_mode(mode_r) : mode_r;
        end
        MODE_SET_H: begin
          // A mode edge in the same cycle swallows the adjust edge.
          sec_inc_r  <= 1'b0;
          min_inc_r  <= 1'b0;
          hour_inc_r <= adj_rise_s & ~mode_rise_s;
          mode_r     <= mode_rise_s ? next_mode(mode_r) : mode_r;
        end
        MODE_SET_M: begin
          // No carry into hours while minutes are being set.
          sec_inc_r  <= 1'b0;
          min_inc_r  <= adj_rise_s & ~mode_rise_s;
          hour_inc_r <= 1'b0;
          mode_r     <= mode_rise_s ? next_mode(mode_r) : mode_r;
        end
        default: begin
          sec_inc_r  <= 1'b0;
          min_inc_r  <= 1'b0;
          hour_inc_r <= 1'b0;
          mode_r     <= MODE_RUN;
        end
      endcase
    end
  end

  assign tick_1hz = tick_1hz_r;
  assign sec_inc  = sec_inc_r;
  assign min_inc  = min_inc_r;
  assign hour_inc = hour_inc_r;
  assign sec_clr  = sec_clr_r;
  assign mode     = mode_r;

`ifdef CLOCK_TICK_CTRL_BLINK_EN
  logic blink_r;

  // Blank strobe: first half of every second while a field is being set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_r <= 1'b0;
    end else begin
      blink_r <= (mode_r != MODE_RUN) && (count_s < CW'(PRESCALE / 2));
    end
  end

  assign blink = blink_r;
`else
  // The count is only needed for the blink strobe.
  logic unused_count_s;
  assign unused_count_s = ^count_s;
  assign blink          = 1'b0;
`endif

endmodule
